// File: rtl/maxpool_scheduler_pkg.sv
// maxpool_scheduler_pkg: shared encodings and layer geometry for the 2x2 max-pool scheduler
package maxpool_scheduler_pkg;
  localparam logic MODE_L1 = 1'b0;
  localparam logic MODE_L2 = 1'b1;
  localparam int MAP_W_L1 = 24;
  localparam int MAP_W_L2 = 8;
  localparam int POOL_W_L1 = 12;
  localparam int POOL_W_L2 = 4;
  localparam int WIN_L1 = 144;
  localparam int WIN_L2 = 16;
  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;
endpackage

// File: rtl/maxpool_scheduler_pool_addr_gen.sv
// pool_addr_gen: window row/col/base/out counters, read-offset mux and last-window flag
module pool_addr_gen
  import maxpool_scheduler_pkg::*;
#(
  parameter int ADDR_BIT = 10,
  parameter int DST_BASE = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                advance,
  input  logic                mode,
  input  logic [1:0]          k,
  output logic [ADDR_BIT-1:0] src_addr,
  output logic [ADDR_BIT-1:0] dst_addr,
  output logic                last
);
  logic [3:0] row, col;
  logic [ADDR_BIT-1:0] base, out_cnt, w;
  logic col_last, row_last;
  assign w = mode ? ADDR_BIT'(MAP_W_L2) : ADDR_BIT'(MAP_W_L1);
  assign col_last = col == (mode ? 4'(POOL_W_L2 - 1) : 4'(POOL_W_L1 - 1));
  assign row_last = row == (mode ? 4'(POOL_W_L2 - 1) : 4'(POOL_W_L1 - 1));
  assign last = col_last && row_last;
  assign src_addr = base + (k[1] ? w : '0) + ADDR_BIT'(k[0]);
  assign dst_addr = ADDR_BIT'(DST_BASE) + out_cnt;
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      row <= '0;
      col <= '0;
      base <= '0;
      out_cnt <= '0;
    end else if (advance) begin
      out_cnt <= out_cnt + ADDR_BIT'(1);
      col <= col_last ? 4'd0 : col + 4'd1;
      row <= col_last ? row + 4'd1 : row;
      base <= base + (col_last ? w + ADDR_BIT'(2) : ADDR_BIT'(2));
    end
  end
endmodule

// File: rtl/maxpool_scheduler.sv
// maxpool_scheduler: FSM sequencing 2x2/stride-2 max-pool reads, datapath strobes and pooled writes
module maxpool_scheduler
  import maxpool_scheduler_pkg::*;
#(
  parameter int ADDR_BIT = 10,
  parameter int DST_BASE = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                mode,
  output logic [ADDR_BIT-1:0] src_addr,
  output logic                src_re,
  output logic                pool_clr,
  output logic                pool_en,
  output logic [ADDR_BIT-1:0] dst_addr,
  output logic                dst_we,
  output logic                busy,
  output logic                done
);
  state_t state, state_n;
  logic [1:0] k;
  logic mode_q, pool_en_q, pool_clr_q, clear, last;
  logic [ADDR_BIT-1:0] gen_src, gen_dst;
  pool_addr_gen #(.ADDR_BIT(ADDR_BIT), .DST_BASE(DST_BASE)) u_gen (
    .clk(clk),
    .rst(rst),
    .clear(clear),
    .advance(dst_we),
    .mode(mode_q),
    .k(k),
    .src_addr(gen_src),
    .dst_addr(gen_dst),
    .last(last)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k <= 2'd0;
      mode_q <= MODE_L1;
      pool_en_q <= 1'b0;
      pool_clr_q <= 1'b0;
    end else begin
      state <= state_n;
      k <= state == READ ? k + 2'd1 : 2'd0;
      mode_q <= clear ? mode : mode_q;
      pool_en_q <= src_re;
      pool_clr_q <= state == READ && k == 2'd0;
    end
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? READ : IDLE;
      READ:    state_n = k == 2'd3 ? WAIT : READ;
      WAIT:    state_n = WRITE;
      WRITE:   state_n = last ? DONE : READ;
      default: state_n = IDLE;
    endcase
  end
  assign clear = state == IDLE && start;
  assign src_re = state == READ;
  assign dst_we = state == WRITE;
  assign done = state == DONE;
  assign busy = state != IDLE;
  assign src_addr = src_re ? gen_src : '0;
  assign dst_addr = dst_we ? gen_dst : '0;
  assign pool_en = pool_en_q;
  assign pool_clr = pool_clr_q;
endmodule

// File: tb/tb_maxpool_scheduler.sv
// tb_maxpool_scheduler: directed cycle-by-cycle check of the max-pool scheduler against a geometry model
module tb_maxpool_scheduler;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, mode = 1'b0;
  logic [9:0] src_addr, dst_addr;
  logic src_re, pool_clr, pool_en, dst_we, busy, done;
  int n_cmp = 0, n_err = 0;
  maxpool_scheduler dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .mode(mode),
    .src_addr(src_addr),
    .src_re(src_re),
    .pool_clr(pool_clr),
    .pool_en(pool_en),
    .dst_addr(dst_addr),
    .dst_we(dst_we),
    .busy(busy),
    .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [25:0] obs();
    return {busy, done, dst_we, src_re, pool_en, pool_clr, src_addr, dst_addr};
  endfunction
  function automatic logic [25:0] exp_word(input logic m, input int c);
    int w, p, n, win, ph, base;
    logic [9:0] sa, da;
    w = m ? 8 : 24;
    p = w / 2;
    n = p * p;
    if (c == 6 * n + 1) return {2'b11, 24'd0};
    if (c < 1 || c > 6 * n) return '0;
    win = (c - 1) / 6;
    ph = (c - 1) % 6;
    base = 2 * (win / p) * w + 2 * (win % p);
    sa = ph < 4 ? 10'(base + (ph >= 2 ? w : 0) + ph % 2) : 10'd0;
    da = ph == 5 ? 10'(win) : 10'd0;
    return {1'b1, 1'b0, ph == 5, ph < 4, ph >= 1 && ph <= 4, ph == 1, sa, da};
  endfunction
  task automatic run_pass(input logic m, input int pulse_at, input int abort_at, input bit hold);
    int n, lim, done_at, w12, win, mx, prev, want;
    int rd[4];
    n = m ? 16 : 144;
    lim = hold ? 6 * n + 3 : 6 * n + 2;
    done_at = -1;
    w12 = -1;
    mx = 0;
    prev = 0;
    start = 1'b1;
    mode = m;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    for (int c = 1; c <= lim; c++) begin
      chk($sformatf("m%0d_c%0d", m, c), 32'(obs()), 32'(exp_word(m, c > 6 * n + 2 ? c - (6 * n + 2) : c)));
      if (done && done_at < 0) done_at = c;
      if (pool_clr) mx = prev;
      else if (pool_en && prev > mx) mx = prev;
      if (dst_we) begin
        win = int'(dst_addr);
        want = m ? 2 * (win / 4) * 8 + 2 * (win % 4) + 9 : 2 * (win / 12) * 24 + 2 * (win % 12) + 25;
        chk($sformatf("max_m%0d_w%0d", m, win), 32'(mx), 32'(want));
      end
      if (c == 6 * 12 + 1) w12 = int'(src_addr);
      if (c > 6 * (n - 1) && c <= 6 * (n - 1) + 4) rd[c - 6 * (n - 1) - 1] = int'(src_addr);
      prev = int'(src_addr);
      if (c == pulse_at) begin
        start = 1'b1;
        mode = ~mode;
      end
      if (c == pulse_at + 1) start = 1'b0;
      if (c == abort_at) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_zero", 32'(obs()), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_idle", 32'(obs()), 32'd0);
        return;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    chk($sformatf("done_at_m%0d", m), 32'(done_at), m ? 32'd97 : 32'd865);
    if (m) begin
      chk("last_rd_l2", {rd[0][7:0], rd[1][7:0], rd[2][7:0], rd[3][7:0]}, {8'd54, 8'd55, 8'd62, 8'd63});
    end else begin
      chk("w12_rd", 32'(w12), 32'd48);
      chk("last_rd_l1", 32'(rd[0] * 1000 + rd[1]), 32'(550 * 1000 + 551));
      chk("last_rd_l1b", 32'(rd[2] * 1000 + rd[3]), 32'(574 * 1000 + 575));
    end
  endtask
  initial begin
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_hold", 32'(obs()), 32'd0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle", 32'(obs()), 32'd0);
    run_pass(1'b1, -10, -1, 1'b0);
    run_pass(1'b0, -10, -1, 1'b0);
    run_pass(1'b1, 40, -1, 1'b0);
    run_pass(1'b1, -10, 35, 1'b0);
    run_pass(1'b1, -10, -1, 1'b0);
    run_pass(1'b1, -10, -1, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("final_rst", 32'(obs()), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("final_idle", 32'(obs()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
